drum_event_spi_tx: RTL and testbench
====================================

Name: drum_event_spi_tx

Overview:
- Consumer end of the drum trigger interface (drum_trigger_valid / drum_code / drum_hand).
- Captures each trigger event once and queues it in a small FIFO.
- Serializes events to the MCU as an SPI mode-0 slave, one 8-bit frame per chip-select assertion.
- Raises irq while events are pending.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchronizer flops on sck, cs_n and mosi.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- drum_trigger_valid  input  1  trigger level; stays high for about 6 clk per event.
- drum_code  input  4  drum identifier, valid while drum_trigger_valid is high.
- drum_hand  input  1  0 = right hand, 1 = left hand.
- sck  input  1  SPI clock from the MCU, asynchronous.
- cs_n  input  1  SPI chip select, active low, asynchronous.
- mosi  input  1  synchronized but ignored; reserved.
- miso  output  1  SPI data out.
- irq  output  1  high while the FIFO is non-empty.
- overflow_sticky  output  1  set when an event is dropped; cleared when reported.

Behaviour:
- Reset: miso=0, irq=0, overflow_sticky=0, FIFO empty, FSM=IDLE, last_evt={0,0}, prev_valid=0.
- Reset mid-frame aborts the frame; the head entry is discarded together with the rest of the FIFO.
- Capture:
  - Push {drum_hand, drum_code} when drum_trigger_valid is high AND (prev_valid=0 OR {drum_hand, drum_code} != last_evt).
  - One push per event. A retrigger of the same drum during the hold window is not separable and is merged (accepted limitation).
  - last_evt updates on every push. prev_valid registers drum_trigger_valid every clk.
- FIFO:
  - Full with no pop: drop the new event and set overflow_sticky.
  - Full with a pop in the same cycle: accept the push; count is unchanged.
  - Empty with a pop: cannot occur, because a pop only follows a frame that was loaded from a non-empty FIFO.
  - irq = (count != 0), registered; 1 clk after the push.
- SPI timing:
  - sck and cs_n pass through SYNC_STAGES flops, then edge detect in clk.
  - clk must be at least 8x sck.
  - The MCU must allow SYNC_STAGES+2 clk between cs_n falling and the first sck rise.
- Frame format, MSB first:
  - bit7 = event present.
  - bit6 = hand.
  - bit5 = overflow flag.
  - bit4 = 0.
  - bits3:0 = code.
  - Empty FIFO: frame is 8'h00, with bit5 = overflow_sticky.
- FSM:
  - IDLE: miso=0. Synchronized cs_n falling -> LOAD.
  - LOAD (1 clk): copy the FIFO head (peek, no pop) or the empty frame into shift_reg; bit_cnt=0; miso=shift_reg[7]; -> SHIFT.
  - SHIFT:
    - On each synced sck rising edge, bit_cnt++.
    - On each synced sck falling edge, shift left and drive the new MSB on miso.
    - When bit_cnt reaches 8 -> COMMIT.
  - COMMIT (1 clk): pop if the frame had bit7=1; clear overflow_sticky if bit5 was sent as 1; -> DONE.
  - DONE: miso=0; wait for cs_n high -> IDLE.
  - cs_n rising in LOAD or SHIFT: abort -> IDLE; no pop, no flag clear; the same event is retransmitted in the next frame.
- A push and overflow_sticky set in the same clk as the COMMIT clear: the set wins.
- Extra sck edges in DONE are ignored.

Decomposition:
- Package drum_pkg:
  - drum_evt_t struct {hand, code[3:0]}.
  - Frame bit-position localparams FRM_PRESENT=7, FRM_HAND=6, FRM_OVF=5.
  - spi_tx_state_t enum {IDLE, LOAD, SHIFT, COMMIT, DONE}.
- Sub-module drum_event_fifo:
  - Synchronous FIFO, parameterised DEPTH.
  - Ports: push, pop, din, dout (head peek), full, empty, count.

Test Plan:
- Single event: valid high 6 clk with code=4'd3, hand=1; one SPI frame -> miso bits 8'hC3, one push only, irq falls after COMMIT.
- Code change during hold: valid stays high, code 3 then 5 after 2 clk, hand=0 -> two entries; frames read 8'h83 then 8'h85.
- Overflow: 9 distinct events with DEPTH=8 and no reads -> overflow_sticky=1; first frame bit5=1 (8'hA?); flag clears after COMMIT; 8 frames drain, then 8'h00.
- Aborted frame: cs_n rises after 4 sck rising edges -> no pop; the next full frame returns the same 8'h83.
- Empty read: no events, full frame -> 8'h00, irq stays 0, FIFO count stays 0.
- Simultaneous push and COMMIT pop with the FIFO full -> push accepted, count stays 8, overflow_sticky stays 0; reset asserted mid-SHIFT -> miso=0, irq=0 next clk.

Source files
------------

// File: rtl/drum_pkg.sv
// rtl/drum_pkg.sv - shared types and frame layout for the drum event SPI path
package drum_pkg;

  typedef struct packed {
    logic       hand;
    logic [3:0] code;
  } drum_evt_t;

  localparam int FRM_PRESENT = 7;
  localparam int FRM_HAND    = 6;
  localparam int FRM_OVF     = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT,
    DONE
  } spi_tx_state_t;

endpackage

// File: rtl/drum_event_fifo.sv
// rtl/drum_event_fifo.sv - synchronous event FIFO with head peek
import drum_pkg::*;

module drum_event_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  drum_evt_t     din,
  output drum_evt_t     dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  drum_evt_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/drum_event_spi_tx.sv
// rtl/drum_event_spi_tx.sv - queues drum triggers and serves them to the MCU over SPI mode 0
import drum_pkg::*;

module drum_event_spi_tx #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       drum_trigger_valid,
  input  logic [3:0] drum_code,
  input  logic       drum_hand,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       irq,
  output logic       overflow_sticky
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] unused_mosi_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_fall;
  logic                   cs_rise;

  drum_evt_t     cur_evt;
  drum_evt_t     last_evt;
  drum_evt_t     head;
  logic          prev_valid;
  logic          push_req;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;

  spi_tx_state_t state;
  logic [7:0]    shift_reg;
  logic [7:0]    frame;
  logic [3:0]    bit_cnt;
  logic          sent_present;
  logic          sent_ovf;

  // Bring the asynchronous SPI pins into clk and keep the previous synced value for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync         <= '0;
      cs_sync          <= '1;
      unused_mosi_sync <= '0;
      sck_d            <= 1'b0;
      cs_d             <= 1'b1;
    end else begin
      sck_sync         <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync          <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      unused_mosi_sync <= {unused_mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d            <= sck_sync[SYNC_STAGES-1];
      cs_d             <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_sync[SYNC_STAGES-1] && !sck_d;
  assign sck_fall = !sck_sync[SYNC_STAGES-1] && sck_d;
  assign cs_fall  = !cs_sync[SYNC_STAGES-1] && cs_d;
  assign cs_rise  = cs_sync[SYNC_STAGES-1] && !cs_d;

  // A trigger level is held for several clocks; only its start or a change of drum counts as new.
  assign cur_evt  = '{hand: drum_hand, code: drum_code};
  assign push_req = drum_trigger_valid && (!prev_valid || cur_evt != last_evt);
  assign pop      = (state == COMMIT) && sent_present;
  assign drop     = push_req && full && !pop;

  // Track the trigger level and the most recent event seen, including dropped ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      last_evt   <= '0;
    end else begin
      prev_valid <= drum_trigger_valid;
      if (push_req) last_evt <= cur_evt;
    end
  end

  drum_event_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (cur_evt),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Frame built from the head entry, or an empty frame still carrying the overflow flag.
  always_comb begin
    frame          = '0;
    frame[FRM_OVF] = overflow_sticky;
    if (!empty) begin
      frame[FRM_PRESENT] = 1'b1;
      frame[FRM_HAND]    = head.hand;
      frame[3:0]         = head.code;
    end
  end

  // Interrupt and overflow status; a fresh drop outranks the clear from a reported frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq             <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      irq <= (fifo_count != '0);
      if (drop)
        overflow_sticky <= 1'b1;
      else if (state == COMMIT && sent_ovf)
        overflow_sticky <= 1'b0;
    end
  end

  // SPI slave frame sequencer: peek on select, shift on sck, consume only after a complete frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      miso         <= 1'b0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      sent_present <= 1'b0;
      sent_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) state <= LOAD;
        end
        LOAD: begin
          if (cs_rise) begin
            state <= IDLE;
            miso  <= 1'b0;
          end else begin
            shift_reg    <= frame;
            miso         <= frame[7];
            bit_cnt      <= '0;
            sent_present <= frame[FRM_PRESENT];
            sent_ovf     <= frame[FRM_OVF];
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            miso  <= 1'b0;
          end else if (bit_cnt == 4'd8) begin
            state <= COMMIT;
          end else begin
            if (sck_rise) bit_cnt <= bit_cnt + 4'd1;
            if (sck_fall) begin
              shift_reg <= {shift_reg[6:0], 1'b0};
              miso      <= shift_reg[6];
            end
          end
        end
        COMMIT: begin
          miso  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          miso <= 1'b0;
          if (cs_sync[SYNC_STAGES-1]) state <= IDLE;
        end
        default: begin
          miso  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drum_event_spi_tx.sv
// tb/tb_drum_event_spi_tx.sv - directed self-checking bench for drum_event_spi_tx
module tb_drum_event_spi_tx;
  import drum_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       drum_trigger_valid;
  logic [3:0] drum_code;
  logic       drum_hand;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       irq;
  logic       overflow_sticky;

  int n_checks = 0;
  int n_errors = 0;

  drum_event_spi_tx #(.DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .drum_trigger_valid (drum_trigger_valid),
    .drum_code          (drum_code),
    .drum_hand          (drum_hand),
    .sck                (sck),
    .cs_n               (cs_n),
    .mosi               (mosi),
    .miso               (miso),
    .irq                (irq),
    .overflow_sticky    (overflow_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_evt(input logic hand, input logic [3:0] code);
    drum_hand          = hand;
    drum_code          = code;
    drum_trigger_valid = 1'b1;
    tick(6);
    drum_trigger_valid = 1'b0;
    tick(2);
  endtask

  task automatic spi_frame(output logic [7:0] data);
    data = '0;
    cs_n = 1'b0;
    tick(6);
    for (int i = 0; i < 8; i++) begin
      data[7-i] = miso;
      sck = 1'b1;
      tick(5);
      sck = 1'b0;
      tick(5);
    end
    cs_n = 1'b1;
    tick(6);
  endtask

  logic [7:0] d;
  logic [7:0] d2;

  initial begin
    rst = 1'b1;
    drum_trigger_valid = 1'b0;
    drum_code = '0;
    drum_hand = 1'b0;
    sck = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(3);
    check("rst_miso", miso, 0);
    check("rst_irq", irq, 0);
    check("rst_ovf", overflow_sticky, 0);
    rst = 1'b0;
    tick(2);

    // single event
    send_evt(1'b1, 4'd3);
    check("single_count", dut.u_fifo.count, 1);
    check("single_irq", irq, 1);
    spi_frame(d);
    check("single_frame", d, 8'hC3);
    check("single_irq_after", irq, 0);

    // code change during a held trigger
    drum_hand = 1'b0;
    drum_code = 4'd3;
    drum_trigger_valid = 1'b1;
    tick(2);
    drum_code = 4'd5;
    tick(4);
    drum_trigger_valid = 1'b0;
    tick(2);
    check("change_count", dut.u_fifo.count, 2);
    spi_frame(d);
    check("change_frame0", d, 8'h83);
    spi_frame(d);
    check("change_frame1", d, 8'h85);

    // overflow with nine distinct events
    for (int i = 1; i <= 9; i++) send_evt(1'b0, 4'(i));
    check("ovf_count", dut.u_fifo.count, 8);
    check("ovf_sticky", overflow_sticky, 1);
    spi_frame(d);
    check("ovf_frame0", d, 8'hA1);
    check("ovf_cleared", overflow_sticky, 0);
    for (int i = 2; i <= 8; i++) begin
      spi_frame(d);
      check("ovf_drain", d, 8'h80 | 8'(i));
    end
    spi_frame(d);
    check("ovf_empty_frame", d, 8'h00);

    // aborted frame keeps the event
    send_evt(1'b0, 4'd3);
    cs_n = 1'b0;
    tick(6);
    for (int i = 0; i < 4; i++) begin
      sck = 1'b1;
      tick(5);
      sck = 1'b0;
      tick(5);
    end
    cs_n = 1'b1;
    tick(6);
    check("abort_count", dut.u_fifo.count, 1);
    spi_frame(d);
    check("abort_retx", d, 8'h83);
    check("abort_drained", dut.u_fifo.count, 0);

    // empty read
    spi_frame(d);
    check("empty_frame", d, 8'h00);
    check("empty_irq", irq, 0);
    check("empty_count", dut.u_fifo.count, 0);

    // push arriving exactly on the COMMIT pop of a full FIFO
    for (int i = 1; i <= 8; i++) send_evt(1'b0, 4'(i));
    check("full_count", dut.u_fifo.count, 8);
    fork
      spi_frame(d2);
      begin
        int n = 0;
        while (dut.state != COMMIT && n < 300) begin
          tick(1);
          n++;
        end
        check("commit_seen", n < 300, 1);
        drum_hand = 1'b1;
        drum_code = 4'd9;
        drum_trigger_valid = 1'b1;
        tick(1);
        check("simul_count", dut.u_fifo.count, 8);
        check("simul_ovf", overflow_sticky, 0);
        tick(5);
        drum_trigger_valid = 1'b0;
      end
    join
    check("simul_frame", d2, 8'h81);

    // reset during SHIFT
    cs_n = 1'b0;
    tick(6);
    sck = 1'b1;
    tick(4);
    check("pre_rst_miso", miso, 1);
    check("pre_rst_irq", irq, 1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_count", dut.u_fifo.count, 0);
    sck = 1'b0;
    cs_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    spi_frame(d);
    check("post_rst_frame", d, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
